edge_gradient_pipeline: RTL and testbench
=========================================

# edge_gradient_pipeline

Streaming front end of the Canny edge detector. Takes a raster-order 8-bit grayscale image, applies a 3×3 Gaussian blur, then a 3×3 Sobel operator on the blurred image. It emits the blurred stream, the per-pixel |Gx|/|Gy|, the gradient magnitude and a thresholded edge pixel. It feeds the non-maximum-suppression stage.

## Interface
- IMG_WIDTH, 512: input pixels per row.
- IMG_HEIGHT, 512: input rows per frame.
- EDGE_THRESHOLD, 100: magnitude at or above which pixel_out is 255.
- clk  in  1: single clock; all logic on rising edge.
- rstN  in  1: reset, synchronous and active-high (despite the name; asserted = 1).
- pixel_in  in  8: raster-order input pixel.
- pixel_in_valid  in  1: pixel_in accepted this cycle; no backpressure.
- gaussian_pixel_out  out  8: blurred pixel.
- gaussian_pixel_out_valid  out  1: strobe for gaussian_pixel_out.
- pixel_out_x  out  8: min(|Gx|,255).
- pixel_out_y  out  8: min(|Gy|,255).
- pixel_xy_valid  out  1: strobe for pixel_out_x/y.
- gradient_magnitude  out  11: |Gx|+|Gy|.
- pixel_out  out  8: 255 if gradient_magnitude ≥ EDGE_THRESHOLD, else 0.
- gradient_out_valid  out  1: strobe for gradient_magnitude and pixel_out.

## Operation
- Stage chain: window_3x3 (width IMG_WIDTH) → Gaussian → window_3x3 (width IMG_WIDTH-2) → Sobel.
- Windows use no padding:
  - Valid only when the accepted pixel has row ≥ 2 and col ≥ 2.
  - Gaussian stream is (W-2)×(H-2) = 510×510.
  - Gradient stream is (W-4)×(H-4) = 508×508.
- window_3x3:
  - Two line buffers of depth width, plus 3×3 shift registers, plus col/row counters.
  - Counters advance only on valid.
  - col wraps at width-1 and row increments; after (height-1, width-1) both return to 0 for the next frame.
  - Window byte p[r][c] is at bits 8*(3r+c)+:8; r=0 is the oldest row, c=0 the oldest column.
- Gaussian:
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - 12-bit unsigned sum, output = sum>>4 (truncate). Never exceeds 255.
- Sobel:
  - Gx = (right column − left column) with weights 1,2,1.
  - Gy = (bottom row − top row) with weights 1,2,1.
  - Both signed 11-bit, range ±1020.
  - Absolute values are 10-bit; magnitude max 2040 fits 11 bits.
- Reset:
  - Clears counters, all valids and all output data to 0.
  - Line buffer contents need not be cleared.
  - Reset mid-frame discards the partial frame; the next valid pixel is (0,0).

## Timing
- Input pixel (r,c) accepted at edge t:
  - window valid at t+1.
  - gaussian_pixel_out (centre r-1,c-1) valid at t+2.
- Gaussian pixel produced at t+2:
  - second window at t+3.
  - pixel_xy_valid at t+4.
  - gradient_out_valid with magnitude and pixel_out at t+5.
- End-to-end: gradient for input centre (r-2,c-2) appears 5 cycles after accepting (r,c).
- Idle input cycles insert matching bubbles in every valid; data values are unchanged by gaps.
- Each valid is a single-cycle strobe per output pixel; no output without a corresponding input.

## Structure
- Shared package (canny_pkg):
  - pixel_t (8-bit) and window_t (72-bit) typedefs.
  - Kernel weight constants.
  - Magnitude width constant (11).
- Sub-module window_3x3 (parameter WIDTH, HEIGHT), instantiated twice.
- Gaussian and Sobel arithmetic live in the top as registered stages.

## Test plan
- Constant image 100:
  - every gaussian output is 100; all gradient outputs are 0 and pixel_out is 0.
  - exactly 260100 gaussian strobes and 258064 gradient strobes per frame.
- Vertical step (cols <256 = 0, ≥256 = 200):
  - gaussian cols 253/254/255/256 = 0/50/150/200.
  - gradient cols 252..255: magnitude 200/600/600/200.
  - pixel_out_x 200/255/255/200, pixel_out_y 0, pixel_out 255; all other columns 0.
- Horizontal step (rows <256 = 0, ≥256 = 200): same values as the vertical step, with x/y swapped, on gradient rows 252..255.
- Same step image with random idle cycles between valid pixels: output values and order are identical, and latency from the last contributing pixel is still 2 or 5 cycles.
- Reset asserted mid-frame:
  - all outputs and valids are 0 the cycle after the reset edge.
  - a fresh full frame then produces correct results starting at output (0,0).
- Latency check: first gaussian strobe 2 cycles after accepting pixel (2,2); first gradient strobe 5 cycles after accepting pixel (4,4).

Source files
------------

// File: rtl/edge_gradient_pipeline_pkg.sv
// Shared types and kernel weights for the Canny front end
// (Gaussian blur followed by Sobel gradient).
package canny_pkg;

    localparam int PIX_W = 8;
    localparam int MAG_W = 11;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [9*PIX_W-1:0] window_t;

    // Gaussian [1 2 1; 2 4 2; 1 2 1], normalised by 16
    localparam logic [11:0] GK_CORNER   = 12'd1;
    localparam logic [11:0] GK_EDGE     = 12'd2;
    localparam logic [11:0] GK_CENTRE   = 12'd4;
    localparam int          GAUSS_SHIFT = 4;

    localparam logic signed [10:0] SK_OUTER = 11'sd1;
    localparam logic signed [10:0] SK_MID   = 11'sd2;

    // Byte p[r][c] of a window; r=0 oldest row, c=0 oldest column
    function automatic pixel_t win_px(input window_t w, input int r, input int c);
        return w[PIX_W*(3*r+c) +: PIX_W];
    endfunction

endpackage

// File: rtl/edge_gradient_pipeline_window_3x3.sv
// 3x3 sliding window over a raster stream using two line buffers.
// A window strobe is produced only when the accepted pixel has row >= 2 and col >= 2.
module window_3x3
    import canny_pkg::*;
#(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic    clk,
    input  logic    rst,
    input  pixel_t  i_pixel,
    input  logic    i_valid,
    output window_t o_window,
    output logic    o_valid
);

    localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
    localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    pixel_t           r_lb_mid [WIDTH];
    pixel_t           r_lb_top [WIDTH];
    window_t          r_win_p0;
    logic             r_vld_p0;
    pixel_t           w_top;
    pixel_t           w_mid;

    assign w_top = r_lb_top[r_col];
    assign w_mid = r_lb_mid[r_col];

    // Line buffers and window data are never reset; stale contents are
    // flushed before row 2 of a new frame can raise a strobe.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_lb_top[r_col] <= w_mid;
            r_lb_mid[r_col] <= i_pixel;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    r_win_p0[PIX_W*(3*r+c) +: PIX_W] <= r_win_p0[PIX_W*(3*r+c+1) +: PIX_W];
                end
            end
            r_win_p0[PIX_W*2 +: PIX_W] <= w_top;
            r_win_p0[PIX_W*5 +: PIX_W] <= w_mid;
            r_win_p0[PIX_W*8 +: PIX_W] <= i_pixel;
        end
    end

    // p0: window strobe and raster position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= i_valid && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
            if (i_valid) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign o_window = r_win_p0;
    assign o_valid  = r_vld_p0;

endmodule

// File: rtl/edge_gradient_pipeline.sv
// Canny front end: 3x3 Gaussian blur, then 3x3 Sobel on the blurred stream,
// producing |Gx|/|Gy|, |Gx|+|Gy| and a thresholded edge pixel.
module edge_gradient_pipeline
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH      = 512,
    parameter int IMG_HEIGHT     = 512,
    parameter int EDGE_THRESHOLD = 100
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [7:0]       pixel_in,
    input  logic             pixel_in_valid,
    output logic [7:0]       gaussian_pixel_out,
    output logic             gaussian_pixel_out_valid,
    output logic [7:0]       pixel_out_x,
    output logic [7:0]       pixel_out_y,
    output logic             pixel_xy_valid,
    output logic [MAG_W-1:0] gradient_magnitude,
    output logic [7:0]       pixel_out,
    output logic             gradient_out_valid
);

    localparam logic [MAG_W-1:0] THRESH = MAG_W'(EDGE_THRESHOLD);

    function automatic logic [11:0] gauss_sum(input window_t w);
        logic [11:0] p [9];
        for (int i = 0; i < 9; i++) p[i] = {4'b0000, w[PIX_W*i +: PIX_W]};
        return GK_CORNER*p[0] + GK_EDGE*p[1]   + GK_CORNER*p[2]
             + GK_EDGE*p[3]   + GK_CENTRE*p[4] + GK_EDGE*p[5]
             + GK_CORNER*p[6] + GK_EDGE*p[7]   + GK_CORNER*p[8];
    endfunction

    function automatic logic signed [10:0] sobel_gx(input window_t w);
        logic signed [10:0] p [9];
        for (int i = 0; i < 9; i++) p[i] = $signed({3'b000, w[PIX_W*i +: PIX_W]});
        return (SK_OUTER*p[2] + SK_MID*p[5] + SK_OUTER*p[8])
             - (SK_OUTER*p[0] + SK_MID*p[3] + SK_OUTER*p[6]);
    endfunction

    function automatic logic signed [10:0] sobel_gy(input window_t w);
        logic signed [10:0] p [9];
        for (int i = 0; i < 9; i++) p[i] = $signed({3'b000, w[PIX_W*i +: PIX_W]});
        return (SK_OUTER*p[6] + SK_MID*p[7] + SK_OUTER*p[8])
             - (SK_OUTER*p[0] + SK_MID*p[1] + SK_OUTER*p[2]);
    endfunction

    // |v| for v in [-1020, 1020] always fits 10 bits
    function automatic logic [9:0] abs10(input logic signed [10:0] v);
        return v[10] ? 10'(-v) : 10'(v);
    endfunction

    function automatic pixel_t sat8(input logic [9:0] v);
        return (v > 10'd255) ? 8'hFF : v[7:0];
    endfunction

    window_t            w_win1_p0;
    logic               w_vld_p0;
    logic [11:0]        w_gsum_p0;
    pixel_t             r_gauss_p1;
    logic               r_vld_p1;
    window_t            w_win2_p2;
    logic               w_vld_p2;
    logic signed [10:0] w_gx_p2;
    logic signed [10:0] w_gy_p2;
    logic [9:0]         r_absx_p3;
    logic [9:0]         r_absy_p3;
    pixel_t             r_satx_p3;
    pixel_t             r_saty_p3;
    logic               r_vld_p3;
    logic [MAG_W-1:0]   w_mag_p3;
    logic [MAG_W-1:0]   r_mag_p4;
    pixel_t             r_edge_p4;
    logic               r_vld_p4;

    window_3x3 #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_win_gauss (
        .clk      (clk),
        .rst      (rstN),
        .i_pixel  (pixel_in),
        .i_valid  (pixel_in_valid),
        .o_window (w_win1_p0),
        .o_valid  (w_vld_p0)
    );

    assign w_gsum_p0 = gauss_sum(w_win1_p0);

    // p1: Gaussian (sum >> 4, truncating; max 4080 >> 4 = 255)
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_gauss_p1 <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_p0;
            if (w_vld_p0) r_gauss_p1 <= pixel_t'(w_gsum_p0 >> GAUSS_SHIFT);
        end
    end

    window_3x3 #(
        .WIDTH  (IMG_WIDTH - 2),
        .HEIGHT (IMG_HEIGHT - 2)
    ) u_win_sobel (
        .clk      (clk),
        .rst      (rstN),
        .i_pixel  (r_gauss_p1),
        .i_valid  (r_vld_p1),
        .o_window (w_win2_p2),
        .o_valid  (w_vld_p2)
    );

    assign w_gx_p2 = sobel_gx(w_win2_p2);
    assign w_gy_p2 = sobel_gy(w_win2_p2);

    // p3: Sobel absolute values
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_absx_p3 <= '0;
            r_absy_p3 <= '0;
            r_satx_p3 <= '0;
            r_saty_p3 <= '0;
            r_vld_p3  <= 1'b0;
        end else begin
            r_vld_p3 <= w_vld_p2;
            if (w_vld_p2) begin
                r_absx_p3 <= abs10(w_gx_p2);
                r_absy_p3 <= abs10(w_gy_p2);
                r_satx_p3 <= sat8(abs10(w_gx_p2));
                r_saty_p3 <= sat8(abs10(w_gy_p2));
            end
        end
    end

    assign w_mag_p3 = {1'b0, r_absx_p3} + {1'b0, r_absy_p3};

    // p4: magnitude and edge threshold
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_mag_p4  <= '0;
            r_edge_p4 <= '0;
            r_vld_p4  <= 1'b0;
        end else begin
            r_vld_p4 <= r_vld_p3;
            if (r_vld_p3) begin
                r_mag_p4  <= w_mag_p3;
                r_edge_p4 <= (w_mag_p3 >= THRESH) ? 8'hFF : 8'h00;
            end
        end
    end

    assign gaussian_pixel_out       = r_gauss_p1;
    assign gaussian_pixel_out_valid = r_vld_p1;
    assign pixel_out_x              = r_satx_p3;
    assign pixel_out_y              = r_saty_p3;
    assign pixel_xy_valid           = r_vld_p3;
    assign gradient_magnitude       = r_mag_p4;
    assign pixel_out                = r_edge_p4;
    assign gradient_out_valid       = r_vld_p4;

endmodule

// File: tb/tb_edge_gradient_pipeline.sv
// Directed bench for edge_gradient_pipeline on a small 16x12 frame with steps at col/row 8.
module tb_edge_gradient_pipeline;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int S  = 8;
    localparam int GW = W - 2;
    localparam int GH = H - 2;
    localparam int DW = W - 4;
    localparam int DH = H - 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic [7:0]  gaussian_pixel_out;
    logic        gaussian_pixel_out_valid;
    logic [7:0]  pixel_out_x;
    logic [7:0]  pixel_out_y;
    logic        pixel_xy_valid;
    logic [10:0] gradient_magnitude;
    logic [7:0]  pixel_out;
    logic        gradient_out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int pc       = 0;
    int img_mode = 0;
    int mon_en   = 0;
    int g_cnt, x_cnt, d_cnt;
    int acc [H][W];

    edge_gradient_pipeline #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .EDGE_THRESHOLD (100)
    ) dut (
        .clk                      (clk),
        .rstN                     (rstN),
        .pixel_in                 (pixel_in),
        .pixel_in_valid           (pixel_in_valid),
        .gaussian_pixel_out       (gaussian_pixel_out),
        .gaussian_pixel_out_valid (gaussian_pixel_out_valid),
        .pixel_out_x              (pixel_out_x),
        .pixel_out_y              (pixel_out_y),
        .pixel_xy_valid           (pixel_xy_valid),
        .gradient_magnitude       (gradient_magnitude),
        .pixel_out                (pixel_out),
        .gradient_out_valid       (gradient_out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pix(input int r, input int c);
        if (img_mode == 0) return 100;
        if (img_mode == 1) return (c >= S) ? 200 : 0;
        return (r >= S) ? 200 : 0;
    endfunction

    // Hand-derived blur of a 0->200 step at index S
    function automatic int step_g(input int j);
        if (j <  S-2) return 0;
        if (j == S-2) return 50;
        if (j == S-1) return 150;
        return 200;
    endfunction

    function automatic int step_d(input int k);
        if (k == S-4) return 200;
        if (k == S-3 || k == S-2) return 600;
        if (k == S-1) return 200;
        return 0;
    endfunction

    function automatic int exp_gauss(input int r, input int c);
        if (img_mode == 0) return 100;
        return (img_mode == 1) ? step_g(c) : step_g(r);
    endfunction

    function automatic int exp_mag(input int r, input int c);
        if (img_mode == 0) return 0;
        return (img_mode == 1) ? step_d(c) : step_d(r);
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Latency counts edges from acceptance to the edge that consumes the output
    initial begin : monitor
        int r, c, m;
        forever begin
            @(negedge clk);
            if (mon_en != 0) begin
                if (gaussian_pixel_out_valid) begin
                    r = g_cnt / GW; c = g_cnt % GW;
                    if (r < GH) begin
                        check_eq("gauss", int'(gaussian_pixel_out), exp_gauss(r, c));
                        check_eq("gauss_lat", pc + 1 - acc[r+2][c+2], 2);
                    end
                    g_cnt++;
                end
                if (pixel_xy_valid) begin
                    r = x_cnt / DW; c = x_cnt % DW;
                    if (r < DH) begin
                        m = exp_mag(r, c);
                        check_eq("grad_x", int'(pixel_out_x), (img_mode == 1) ? sat(m) : 0);
                        check_eq("grad_y", int'(pixel_out_y), (img_mode == 2) ? sat(m) : 0);
                        check_eq("xy_lat", pc + 1 - acc[r+4][c+4], 4);
                    end
                    x_cnt++;
                end
                if (gradient_out_valid) begin
                    r = d_cnt / DW; c = d_cnt % DW;
                    if (r < DH) begin
                        m = exp_mag(r, c);
                        check_eq("grad_mag", int'(gradient_magnitude), m);
                        check_eq("edge_pix", int'(pixel_out), (m >= 100) ? 255 : 0);
                        check_eq("grad_lat", pc + 1 - acc[r+4][c+4], 5);
                    end
                    d_cnt++;
                end
            end
        end
    end

    task automatic send(input int r, input int c);
        pixel_in       = 8'(pix(r, c));
        pixel_in_valid = 1'b1;
        @(posedge clk); #1;
        acc[r][c]      = pc;
        pixel_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_frame(input int m);
        img_mode = m;
        g_cnt = 0; x_cnt = 0; d_cnt = 0;
        mon_en = 1;
    endtask

    task automatic run_frame(input int m, input bit gaps);
        start_frame(m);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r, c);
                if (gaps) idle($urandom_range(0, 2));
            end
        end
        idle(8);
        check_eq("n_gauss", g_cnt, GW*GH);
        check_eq("n_xy", x_cnt, DW*DH);
        check_eq("n_grad", d_cnt, DW*DH);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_gauss"},   int'(gaussian_pixel_out), 0);
        check_eq({pfx, "_gvld"},    int'(gaussian_pixel_out_valid), 0);
        check_eq({pfx, "_x"},       int'(pixel_out_x), 0);
        check_eq({pfx, "_y"},       int'(pixel_out_y), 0);
        check_eq({pfx, "_xyvld"},   int'(pixel_xy_valid), 0);
        check_eq({pfx, "_mag"},     int'(gradient_magnitude), 0);
        check_eq({pfx, "_pix"},     int'(pixel_out), 0);
        check_eq({pfx, "_gradvld"}, int'(gradient_out_valid), 0);
    endtask

    initial begin
        rstN           = 1'b1;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rstN = 1'b0;
        idle(1);

        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b1);
        run_frame(2, 1'b1);

        // Partial vertical-step frame leaves non-zero data in flight
        start_frame(1);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r < 5 || c < 12) send(r, c);
            end
        end
        idle(2);
        check_eq("pre_rst_gauss", int'(gaussian_pixel_out), 200);
        mon_en = 0;
        rstN = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_rst");
        rstN = 1'b0;
        idle(2);
        run_frame(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
